v810_bus_ctrl: RTL

//  External-bus wait-state / chip-select controller on the v810_mem bus side (A, BCYSTn, MRQn, DAn, RW).

---
 rtl/v810_bus_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/v810_bus_ctrl.sv
// External-bus chip-select / wait-state controller for the v810 memory bus side.
// Optional build macro V810_BUS_CTRL_TIMEOUT_EN adds a WAITn stall timeout that raises BERR.
module v810_bus_ctrl #(
    parameter logic [15:0] WS_DEFAULT  = 16'h0000,
    parameter logic [3:0]  W16_DEFAULT = 4'b0000,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic [31:0] A,
    input  logic        BCYSTn,
    input  logic        MRQn,
    input  logic        DAn,
    input  logic        RW,
    input  logic        WAITn,
    output logic        READYn,
    output logic        SZRQn,
    output logic [3:0]  CSn,
    output logic        OEn,
    output logic        WEn,
    output logic        BUSY,
    output logic        BERR,
    input  logic        CFG_WE,
    input  logic [1:0]  CFG_IDX,
    input  logic [4:0]  CFG_WD
);

    localparam int unsigned NREG = 4;
    localparam int unsigned WS_W = 4;
    localparam int unsigned TO_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RDY  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        reg_q, reg_d;
    logic              mem_q, mem_d;
    logic              rw_q, rw_d;
    logic              w16_q, w16_d;
    logic [WS_W-1:0]   cnt_q, cnt_d;
    logic              berr_d;
    logic [TO_W-1:0]   to_q, to_d;

    logic [WS_W-1:0]   ws_q [NREG];
    logic [NREG-1:0]   w16cfg_q;

    logic              ready_d, szrq_d, oen_d, wen_d, busy_d, berr_out_d;
    logic [3:0]        csn_d;

    logic              unused_ok;
    assign unused_ok = ^{A[29:0], TO_W'(TIMEOUT)};

    // State, latched cycle attributes, registered outputs and region config
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q  <= S_IDLE;
            reg_q    <= 2'd0;
            mem_q    <= 1'b0;
            rw_q     <= 1'b0;
            w16_q    <= 1'b0;
            cnt_q    <= '0;
            to_q     <= '0;
            READYn   <= 1'b1;
            SZRQn    <= 1'b1;
            CSn      <= 4'hF;
            OEn      <= 1'b1;
            WEn      <= 1'b1;
            BUSY     <= 1'b0;
            BERR     <= 1'b0;
            w16cfg_q <= W16_DEFAULT;
            for (int i = 0; i < NREG; i++) begin
                ws_q[i] <= WS_DEFAULT[WS_W*i +: WS_W];
            end
        end else if (CE) begin
            state_q <= state_d;
            reg_q   <= reg_d;
            mem_q   <= mem_d;
            rw_q    <= rw_d;
            w16_q   <= w16_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            READYn  <= ready_d;
            SZRQn   <= szrq_d;
            CSn     <= csn_d;
            OEn     <= oen_d;
            WEn     <= wen_d;
            BUSY    <= busy_d;
            BERR    <= berr_out_d;
            if (CFG_WE) begin
                ws_q[CFG_IDX]     <= CFG_WD[3:0];
                w16cfg_q[CFG_IDX] <= CFG_WD[4];
            end
        end
    end

    // Next-state: cnt holds remaining fixed waits minus one, so WAITn is sampled in the last wait cycle
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        mem_d   = mem_q;
        rw_d    = rw_q;
        w16_d   = w16_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        berr_d  = 1'b0;
        case (state_q)
            S_IDLE, S_RDY: begin
                if (!BCYSTn) begin
                    reg_d = A[31:30];
                    mem_d = !MRQn;
                    rw_d  = RW;
                    w16_d = !MRQn && w16cfg_q[A[31:30]];
                    to_d  = '0;
                    if (!MRQn && (ws_q[A[31:30]] != '0)) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_W'(ws_q[A[31:30]] - WS_W'(1));
                    end else begin
                        state_d = S_RDY;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (DAn) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = WS_W'(cnt_q - WS_W'(1));
                end else if (WAITn) begin
                    state_d = S_RDY;
                end else begin
`ifdef V810_BUS_CTRL_TIMEOUT_EN
                    if (to_q == TO_W'(TIMEOUT - 1)) begin
                        state_d = S_RDY;
                        berr_d  = 1'b1;
                    end else begin
                        to_d = TO_W'(to_q + TO_W'(1));
                    end
`else
                    to_d = to_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is registered
    always_comb begin
        ready_d    = 1'b1;
        szrq_d     = 1'b1;
        csn_d      = 4'hF;
        oen_d      = 1'b1;
        wen_d      = 1'b1;
        busy_d     = 1'b0;
        berr_out_d = 1'b0;
        if (state_d != S_IDLE) begin
            busy_d = 1'b1;
            if (mem_d) begin
                csn_d = ~(4'b0001 << reg_d);
                oen_d = !rw_d;
                wen_d = rw_d;
            end
        end
        if (state_d == S_RDY) begin
            ready_d    = 1'b0;
            szrq_d     = !w16_d;
            berr_out_d = berr_d;
        end
    end

endmodule
